// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the serial BCD adder/subtractor.
//   bcd_digit_t - one packed BCD digit (4 bits)
//   state_e     - controller states IDLE / RUN / DONE
//   BCD_MAX     - largest legal digit value (9)
//   BCD_CORR    - decimal correction added when a digit sum exceeds 9 (6)
//   nines_comp  - per-digit nines' complement used to turn A-B into A+B'+1
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_CORR = 4'd6;

  // Nibbles above 9 wrap modulo 16; the result is deterministic, not meaningful.
  function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
    return BCD_MAX - d;
  endfunction

endpackage

// File: rtl/bcd_digit_slice.sv
// bcd_digit_slice: combinational single-digit BCD adder with +6 correction.
// Ports:
//   a, b   in  BCD digits
//   cin    in  decimal carry in
//   digit  out corrected BCD digit
//   cout   out decimal carry out
module bcd_digit_slice
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       cin,
  output bcd_digit_t digit,
  output logic       cout
);

  logic [4:0] s;

  always_comb begin
    s     = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    cout  = (s > 5'(BCD_MAX));
    // Adding 6 skips the six unused codes so the low nibble wraps to the
    // correct decimal digit; the bit that falls out of it is the carry.
    digit = cout ? 4'(s + 5'(BCD_CORR)) : s[3:0];
  end

endmodule

// File: rtl/bcd_serial_addsub.sv
// bcd_serial_addsub: multi-digit BCD adder/subtractor, one digit per clock,
// least significant digit first, through a single shared digit slice.
// Optional feature macro: BCD_DIGIT_CHECK_EN (flags nibbles > 9 on err).
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   a, b                 BCD operands, digit 0 in bits [3:0]
//   cin                  carry-in (add) or borrow-in (sub)
//   sub                  0 = A+B+cin, 1 = A-B-cin (ten's complement result)
//   out_valid/out_ready  result handshake; sum/cout/err hold while stalled
//   sum, cout            BCD result and carry-out / borrow-out
//   err                  some operand nibble was > 9 (0 without the macro)
module bcd_serial_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_e                   state_q;
  logic [CW-1:0]            cnt_q;
  logic [DIGITS-1:0][3:0]   a_q, b_q, sum_q;
  logic [DIGITS-1:0][3:0]   b_eff;
  logic                     carry_q, sub_q, in_ready_q, out_valid_q, cout_q;
  bcd_digit_t               da, db, dig;
  logic                     dcy;

  // Subtraction becomes A + nines(B) + ~borrow; done once at capture.
  for (genvar i = 0; i < DIGITS; i++) begin : g_beff
    assign b_eff[i] = sub ? nines_comp(b[4*i +: 4]) : b[4*i +: 4];
  end

  // Digit select for the shared slice.
  always_comb begin
    da = '0;
    db = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        da = a_q[i];
        db = b_q[i];
      end
    end
  end

  bcd_digit_slice u_slice (
    .a     (da),
    .b     (db),
    .cin   (carry_q),
    .digit (dig),
    .cout  (dcy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b_eff;
            carry_q    <= sub ? ~cin : cin;
            sub_q      <= sub;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) sum_q[i] <= dig;
          end
          carry_q <= dcy;
          if (cnt_q == LAST) begin
            // A final carry of 1 in subtract mode means no borrow.
            cout_q      <= sub_q ? ~dcy : dcy;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
  function automatic logic has_bad(input logic [4*DIGITS-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) r = r | (v[4*i +: 4] > BCD_MAX);
    return r;
  endfunction

  logic err_q;

  // Checked on the raw operands, before any complementing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_q <= 1'b0;
    else if (state_q == IDLE && in_valid) err_q <= has_bad(a) | has_bad(b);
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iv4, ir4, cin4, sub4, ov4, or4, cout4, err4;
  logic [15:0] a4, b4, sum4;
  logic        iv1, ir1, cin1, sub1, ov1, or1, cout1, err1;
  logic [3:0]  a1, b1, sum1;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] exp_sum;
  logic        exp_cout, exp_err;

  always #5 clk = ~clk;

  bcd_serial_addsub #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(sum4),
    .cout(cout4), .err(err4)
  );

  bcd_serial_addsub #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1),
    .cout(cout1), .err(err1)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co;
    int          hold;
  } vec_t;

  // Hand-computed expectations.
  vec_t tv [8] = '{
    '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 0},
    '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0},
    '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 0},
    '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b0, 0},
    '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b1, 0},
    '{16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3765, 1'b0, 0},
    '{16'h2500, 16'h2500, 1'b0, 1'b0, 16'h5000, 1'b0, 3},
    '{16'h000A, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 0}
  };

  // Decimal model: plain integer arithmetic modulo 10^4.
  function automatic bit valid_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int x);
    logic [15:0] r;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model(input logic [15:0] av, bv, input logic ci, sb,
                       output logic [15:0] s, output logic co);
    int t;
    if (!sb) begin
      t  = bcd2int(av) + bcd2int(bv) + int'(ci);
      co = (t >= 10000);
      s  = int2bcd(t % 10000);
    end else begin
      t  = bcd2int(av) - bcd2int(bv) - int'(ci);
      co = (t < 0);
      s  = int2bcd(t < 0 ? t + 10000 : t);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // One clock; the scoreboard compares every cycle the result is presented.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (ov4) begin
      vectors++;
      if (sum4 !== exp_sum || cout4 !== exp_cout || err4 !== exp_err) begin
        miscompares++;
        $display("FAIL scoreboard: sum=%h cout=%b err=%b, expected sum=%h cout=%b err=%b",
                 sum4, cout4, err4, exp_sum, exp_cout, exp_err);
      end
    end
  endtask

  task automatic run4(input vec_t v);
    int n;
    logic [15:0] ms;
    logic mc;
    n = 0;
    while (!ir4 && n < 20) begin cyc(); n++; end
    a4 = v.a; b4 = v.b; cin4 = v.cin; sub4 = v.sub; iv4 = 1'b1;
    if (valid_bcd(v.a) && valid_bcd(v.b)) begin
      model(v.a, v.b, v.cin, v.sub, ms, mc);
      exp_sum = ms; exp_cout = mc; exp_err = 1'b0;
    end else begin
      exp_sum = v.s; exp_cout = v.co; exp_err = CHK;
    end
    cyc();
    iv4 = 1'b0;
    n = 0;
    while (!ov4 && n < 20) begin cyc(); n++; end
    chk("latency", n, 4);
    chk("sum", sum4, v.s);
    chk("cout", cout4, v.co);
    chk("in_ready_done", ir4, 1'b0);
    if (v.hold > 0) begin
      iv4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222;
      for (int k = 0; k < v.hold; k++) begin
        cyc();
        chk("bp_out_valid", ov4, 1'b1);
        chk("bp_in_ready", ir4, 1'b0);
        chk("bp_sum", sum4, v.s);
      end
    end
    or4 = 1'b1;
    cyc();
    or4 = 1'b0;
    chk("release_out_valid", ov4, 1'b0);
    chk("release_in_ready", ir4, 1'b1);
    iv4 = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    rst = 1'b1;
    iv4 = 0; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0; or4 = 0;
    iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; sub1 = 0; or1 = 0;
    exp_sum = '0; exp_cout = 0; exp_err = 0;
    #12;
    chk("rst_in_ready", ir4, 1'b1);
    chk("rst_out_valid", ov4, 1'b0);
    chk("rst_sum", sum4, 16'h0);
    chk("rst_cout", cout4, 1'b0);
    chk("rst_err", err4, 1'b0);
    rst = 1'b0;

    foreach (tv[i]) run4(tv[i]);

    // Reset in the middle of 4321+1111.
    a4 = 16'h4321; b4 = 16'h1111; cin4 = 0; sub4 = 0; iv4 = 1'b1;
    cyc();
    iv4 = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", ov4, 1'b0);
    chk("midrst_in_ready", ir4, 1'b1);
    chk("midrst_sum", sum4, 16'h0);
    chk("midrst_cout", cout4, 1'b0);
    chk("midrst_err", err4, 1'b0);
    cyc();
    rst = 1'b0;
    seen = 0;
    repeat (6) begin cyc(); if (ov4) seen = 1; end
    chk("no_emit_after_rst", seen, 1'b0);
    run4('{16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 0});

    // Single-digit instance: 5+7 and 3-5.
    a1 = 4'd5; b1 = 4'd7; cin1 = 0; sub1 = 0; iv1 = 1'b1;
    cyc();
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin cyc(); n++; end
    chk("d1_latency", n, 1);
    chk("d1_sum", sum1, 4'd2);
    chk("d1_cout", cout1, 1'b1);
    chk("d1_err", err1, 1'b0);
    or1 = 1'b1; cyc(); or1 = 1'b0;
    chk("d1_release", ov1, 1'b0);
    a1 = 4'd3; b1 = 4'd5; sub1 = 1'b1; iv1 = 1'b1;
    cyc();
    iv1 = 1'b0;
    n = 0;
    while (!ov1 && n < 20) begin cyc(); n++; end
    chk("d1_sub_sum", sum1, 4'd8);
    chk("d1_sub_cout", cout1, 1'b1);
    or1 = 1'b1; cyc(); or1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
